// File: rtl/snoop_responder.sv
// snoop_responder
//   Per-sector coherence state table plus a snoop FSM that answers remote bus
//   transactions: hits on readable copies pulse SHR/SHW, dirty copies are
//   written back (send_abort held while the write-back runs), and shared or
//   exclusive copies hit by a write are invalidated.
//
// Ports
//   clk              single clock, rising edge
//   reset            asynchronous, active-low
//   bus_valid        remote transaction present this cycle
//   bus_op           00 read-shared, 01 read-exclusive, 10 write-miss, 11 invalidate
//   bus_sector       target sector of the remote transaction
//   lcl_we           local controller state write strobe
//   lcl_sector       sector written by the local controller
//   lcl_state        state value written by the local controller
//   wb_ack           memory accepted one write-back beat
//   SHR / SHW        snoop hit on read / on write (1-cycle pulses)
//   send_abort       level; requester must retry
//   wb_req           level; write-back beat request
//   write_back_done  1-cycle pulse at the end of a write-back
//   AllInvDone       1-cycle pulse after the local copy was invalidated
//   bus_retry        1-cycle pulse; remote transaction refused while busy
//   busy             FSM not IDLE
module snoop_responder #(
  parameter int unsigned WB_BEATS = 4,
  parameter int unsigned NSECT_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bus_valid,
  input  logic [1:0]         bus_op,
  input  logic [NSECT_W-1:0] bus_sector,
  input  logic               lcl_we,
  input  logic [NSECT_W-1:0] lcl_sector,
  input  logic [2:0]         lcl_state,
  input  logic               wb_ack,
  output logic               SHR,
  output logic               SHW,
  output logic               send_abort,
  output logic               wb_req,
  output logic               write_back_done,
  output logic               AllInvDone,
  output logic               bus_retry,
  output logic               busy
);

  localparam int unsigned NSECT = 1 << NSECT_W;
  localparam logic [3:0]  BEATS = 4'(WB_BEATS);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_WRITEBACK = 3'd2;
  localparam logic [2:0] ST_WB_DONE   = 3'd3;
  localparam logic [2:0] ST_INV_ACK   = 3'd4;

  localparam logic [2:0] S_INVALID   = 3'b000;
  localparam logic [2:0] S_SHARED_1  = 3'b001;
  localparam logic [2:0] S_EXCLUSIVE = 3'b010;
  localparam logic [2:0] S_MODIFIED  = 3'b011;
  localparam logic [2:0] S_START_WB  = 3'b101;

  logic [2:0]             state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [NSECT_W-1:0]     sec_q, sec_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NSECT-1:0][2:0]  sect_q, sect_d;
  logic                   shr_q, shr_d;
  logic                   shw_q, shw_d;
  logic                   abort_q, abort_d;
  logic                   wbd_q, wbd_d;
  logic                   aid_q, aid_d;
  logic                   retry_q, retry_d;

  logic                   snp_we;
  logic [2:0]             snp_state;
  logic                   rd_op;
  logic [2:0]             cur_state;

  assign rd_op     = ~op_q[1];
  assign cur_state = sect_q[sec_q];
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sec_d     = sec_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    shr_d     = 1'b0;
    shw_d     = 1'b0;
    wbd_d     = 1'b0;
    aid_d     = 1'b0;
    snp_we    = 1'b0;
    snp_state = S_INVALID;
    retry_d   = bus_valid & busy;

    case (state_q)
      ST_IDLE: begin
        if (bus_valid) begin
          op_d    = bus_op;
          sec_d   = bus_sector;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        state_d = ST_IDLE;
        case (cur_state)
          S_SHARED_1, S_EXCLUSIVE: begin
            if (rd_op) begin
              shr_d     = 1'b1;
              snp_we    = 1'b1;
              snp_state = S_SHARED_1;
            end else begin
              shw_d     = 1'b1;
              snp_we    = 1'b1;
              snp_state = S_INVALID;
              state_d   = ST_INV_ACK;
            end
          end
          S_MODIFIED: begin
            shr_d     = rd_op;
            shw_d     = ~rd_op;
            abort_d   = 1'b1;
            snp_we    = 1'b1;
            snp_state = S_START_WB;
            cnt_d     = '0;
            state_d   = ST_WRITEBACK;
          end
          default: ;
        endcase
      end
      ST_WRITEBACK: begin
        if (wb_ack) begin
          cnt_d = cnt_q + 4'd1;
          // Leaving on the final ack drops wb_req at that same edge.
          if (cnt_q + 4'd1 == BEATS) state_d = ST_WB_DONE;
        end
      end
      ST_WB_DONE: begin
        wbd_d     = 1'b1;
        abort_d   = 1'b0;
        snp_we    = 1'b1;
        snp_state = rd_op ? S_SHARED_1 : S_INVALID;
        state_d   = ST_IDLE;
      end
      ST_INV_ACK: begin
        aid_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Local writes to the sector under snoop are dropped while busy; the snoop
  // update is applied last so it wins any same-sector collision.
  always_comb begin
    sect_d = sect_q;
    if (lcl_we && !(busy && (lcl_sector == sec_q)))
      sect_d[lcl_sector] = lcl_state;
    if (snp_we)
      sect_d[sec_q] = snp_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      sec_q   <= '0;
      cnt_q   <= '0;
      sect_q  <= '0;
      shr_q   <= 1'b0;
      shw_q   <= 1'b0;
      abort_q <= 1'b0;
      wbd_q   <= 1'b0;
      aid_q   <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      sect_q  <= sect_d;
      shr_q   <= shr_d;
      shw_q   <= shw_d;
      abort_q <= abort_d;
      wbd_q   <= wbd_d;
      aid_q   <= aid_d;
      retry_q <= retry_d;
    end
  end

  assign SHR             = shr_q;
  assign SHW             = shw_q;
  assign send_abort      = abort_q;
  assign wb_req          = (state_q == ST_WRITEBACK);
  assign write_back_done = wbd_q;
  assign AllInvDone      = aid_q;
  assign bus_retry       = retry_q;

endmodule
